// File: rtl/sram_interface_pkg.sv
// Shared command codes, state encoding and widths for the SRAM interface.
// Command codes are also decoded by the upstream memory controller.
package sram_interface_pkg;

  localparam int ADDR_W = 18;
  localparam int DATA_W = 16;
  localparam int CNT_W  = 8;

  localparam logic [1:0] CMD_IDLE  = 2'b00;
  localparam logic [1:0] CMD_READ  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ACCESS,
    S_WR_SETUP,
    S_WR_PULSE,
    S_WR_HOLD,
    S_RELEASE
  } state_t;

  function automatic logic [1:0] ce_sel(input logic cs);
    return cs ? 2'b01 : 2'b10;
  endfunction

endpackage

// File: rtl/sram_interface_dq_io.sv
// Bidirectional SRAM data bus buffer.
// Drives the bus only when dq_oe is set; always returns the bus value.
module sram_interface_dq_io
  import sram_interface_pkg::*;
(
  input  logic [DATA_W-1:0] dq_out,
  input  logic              dq_oe,
  output logic [DATA_W-1:0] dq_in,
  inout  wire  [DATA_W-1:0] dq
);

  assign dq    = dq_oe ? dq_out : {DATA_W{1'bz}};
  assign dq_in = dq;

endmodule

// File: rtl/sram_interface.sv
// Single-word read/write sequencer for two async 256Kx16 SRAMs.
// Fixed-cycle CE/OE/WE timing; all pin outputs registered.
module sram_interface
  import sram_interface_pkg::*;
#(
  parameter int RD_WAIT_CYCLES  = 3,
  parameter int WR_PULSE_CYCLES = 2
) (
  input  logic              CLK_48MHZ,
  input  logic              RESET,
  input  logic [1:0]        CMD_IN,
  input  logic [ADDR_W-1:0] ADDRESS_IN,
  input  logic              CHIP_SELECT_IN,
  input  logic [DATA_W-1:0] DATA_IN,
  output logic              SRAM_STATUS,
  output logic [DATA_W-1:0] READ_DATA,
  output logic              READ_VALID,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  output logic [1:0]        SRAM_CE_N,
  output logic              SRAM_OE_N,
  output logic              SRAM_WE_N,
  inout  wire  [DATA_W-1:0] SRAM_DQ
);

  state_t             state, nxt_state;
  logic [CNT_W-1:0]   cnt, nxt_cnt;
  logic [ADDR_W-1:0]  nxt_addr;
  logic [1:0]         nxt_ce;
  logic               nxt_oe, nxt_we;
  logic               dq_oe, nxt_dq_oe;
  logic [DATA_W-1:0]  dq_out, nxt_dq_out;
  logic [DATA_W-1:0]  dq_in;
  logic [DATA_W-1:0]  nxt_rdata;
  logic               nxt_rvalid;
  logic               idle_pins;

  sram_interface_dq_io u_io (
    .dq_out (dq_out),
    .dq_oe  (dq_oe),
    .dq_in  (dq_in),
    .dq     (SRAM_DQ)
  );

  // Busy is combinational so a new command sees busy in its own cycle
  assign SRAM_STATUS = (state != S_IDLE)
                     || (CMD_IN == CMD_READ)
                     || (CMD_IN == CMD_WRITE);

  always_comb begin
    nxt_state  = state;
    nxt_cnt    = cnt;
    nxt_addr   = SRAM_ADDR;
    nxt_ce     = SRAM_CE_N;
    nxt_oe     = SRAM_OE_N;
    nxt_we     = SRAM_WE_N;
    nxt_dq_oe  = dq_oe;
    nxt_dq_out = dq_out;
    nxt_rdata  = READ_DATA;
    nxt_rvalid = 1'b0;
    idle_pins  = 1'b0;
    case (state)
      S_IDLE: begin
        if (CMD_IN == CMD_READ) begin
          nxt_addr  = ADDRESS_IN;
          nxt_ce    = ce_sel(CHIP_SELECT_IN);
          nxt_oe    = 1'b0;
          nxt_cnt   = CNT_W'(RD_WAIT_CYCLES - 1);
          nxt_state = S_RD_ACCESS;
        end else if (CMD_IN == CMD_WRITE) begin
          nxt_addr   = ADDRESS_IN;
          nxt_ce     = ce_sel(CHIP_SELECT_IN);
          nxt_we     = 1'b1;
          nxt_dq_out = DATA_IN;
          nxt_dq_oe  = 1'b1;
          nxt_state  = S_WR_SETUP;
        end
      end
      S_RD_ACCESS: begin
        if (cnt != '0) begin
          nxt_cnt = cnt - 1'b1;
        end else begin
          nxt_rdata  = dq_in;
          nxt_rvalid = 1'b1;
          idle_pins  = 1'b1;
          nxt_state  = S_RELEASE;
        end
      end
      S_WR_SETUP: begin
        nxt_we    = 1'b0;
        nxt_cnt   = CNT_W'(WR_PULSE_CYCLES - 1);
        nxt_state = S_WR_PULSE;
      end
      S_WR_PULSE: begin
        if (cnt != '0) begin
          nxt_cnt = cnt - 1'b1;
        end else begin
          nxt_we    = 1'b1;
          nxt_state = S_WR_HOLD;
        end
      end
      S_WR_HOLD: begin
        idle_pins = 1'b1;
        nxt_state = S_RELEASE;
      end
      S_RELEASE: begin
        idle_pins = 1'b1;
        // Wait for the command to drop so a held command is not re-run
        if (CMD_IN == CMD_IDLE) nxt_state = S_IDLE;
      end
      default: begin
        idle_pins = 1'b1;
        nxt_state = S_IDLE;
      end
    endcase
    if (idle_pins) begin
      nxt_ce    = 2'b11;
      nxt_oe    = 1'b1;
      nxt_we    = 1'b1;
      nxt_dq_oe = 1'b0;
    end
  end

  always_ff @(posedge CLK_48MHZ) begin
    if (!RESET) begin
      state      <= S_IDLE;
      cnt        <= '0;
      SRAM_ADDR  <= '0;
      SRAM_CE_N  <= 2'b11;
      SRAM_OE_N  <= 1'b1;
      SRAM_WE_N  <= 1'b1;
      dq_oe      <= 1'b0;
      dq_out     <= '0;
      READ_DATA  <= '0;
      READ_VALID <= 1'b0;
    end else begin
      state      <= nxt_state;
      cnt        <= nxt_cnt;
      SRAM_ADDR  <= nxt_addr;
      SRAM_CE_N  <= nxt_ce;
      SRAM_OE_N  <= nxt_oe;
      SRAM_WE_N  <= nxt_we;
      dq_oe      <= nxt_dq_oe;
      dq_out     <= nxt_dq_out;
      READ_DATA  <= nxt_rdata;
      READ_VALID <= nxt_rvalid;
    end
  end

endmodule

// File: tb/tb_sram_interface.sv
// Scoreboard bench for sram_interface with a two-chip async SRAM model.
// Read results are queued at issue and checked by a separate monitor.
module tb_sram_interface;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  cmd;
  logic [17:0] addr_in;
  logic        cs_in;
  logic [15:0] data_in;
  logic        status;
  logic [15:0] rdata;
  logic        rvalid;
  logic [17:0] sram_addr;
  logic [1:0]  ce_n;
  logic        oe_n;
  logic        we_n;
  wire  [15:0] sram_dq;

  logic        model_drive = 1'b0;
  logic [15:0] model_word = '0;
  int          oe_cnt = 0;
  int          viol = 0;
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;

  logic [15:0] mem0 [logic [17:0]];
  logic [15:0] mem1 [logic [17:0]];

  typedef struct {
    logic [15:0] data;
    int          due;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  assign sram_dq = model_drive ? model_word : 16'hzzzz;

  sram_interface dut (
    .CLK_48MHZ      (clk),
    .RESET          (rst_n),
    .CMD_IN         (cmd),
    .ADDRESS_IN     (addr_in),
    .CHIP_SELECT_IN (cs_in),
    .DATA_IN        (data_in),
    .SRAM_STATUS    (status),
    .READ_DATA      (rdata),
    .READ_VALID     (rvalid),
    .SRAM_ADDR      (sram_addr),
    .SRAM_CE_N      (ce_n),
    .SRAM_OE_N      (oe_n),
    .SRAM_WE_N      (we_n),
    .SRAM_DQ        (sram_dq)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // SRAM model: stores while WE low, drives 2 cycles after OE falls
  always @(negedge clk) begin
    if (rst_n) begin
      if (!oe_n && !we_n) viol++;
      if (ce_n == 2'b00) viol++;
      if (dut.dq_oe && !oe_n) viol++;
      if (dut.dq_oe && model_drive) viol++;
      if (!we_n && ce_n != 2'b11) begin
        if (!ce_n[0]) mem0[sram_addr] = sram_dq;
        if (!ce_n[1]) mem1[sram_addr] = sram_dq;
      end
    end
    if (!oe_n && ce_n != 2'b11) oe_cnt++;
    else oe_cnt = 0;
    model_word = '0;
    if (!ce_n[0] && mem0.exists(sram_addr)) model_word = mem0[sram_addr];
    if (!ce_n[1] && mem1.exists(sram_addr)) model_word = mem1[sram_addr];
    model_drive = (oe_cnt >= 2);
  end

  // Read-result monitor
  always @(negedge clk) begin
    if (rst_n && rvalid) begin
      if (exp_q.size() == 0) begin
        chk("rd_unexpected_valid", 32'(rvalid), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rd_data", 32'(rdata), 32'(e.data));
        chk("rd_latency", 32'(cyc), 32'(e.due));
      end
    end
  end

  task automatic do_write(input logic cs, input logic [17:0] a,
                          input logic [15:0] d, input int hold);
    int we_low = 0;
    int dq_ok = 0;
    int ce_ok = 0;
    int hold_bad = 0;
    @(negedge clk);
    cmd = 2'b10; cs_in = cs; addr_in = a; data_in = d;
    #1 chk("wr_status_same_cycle", 32'(status), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 0 && hold == 0) cmd = 2'b00;
      if (!we_n) we_low++;
      if (i < 4) begin
        if (dut.dq_oe && sram_dq == d) dq_ok++;
        if (ce_n == (cs ? 2'b01 : 2'b10) && sram_addr == a) ce_ok++;
      end
    end
    chk("wr_we_low_cycles", 32'(we_low), 32'd2);
    chk("wr_dq_driven", 32'(dq_ok), 32'd4);
    chk("wr_ce_addr", 32'(ce_ok), 32'd4);
    chk("wr_release_ce", 32'(ce_n), 32'(2'b11));
    chk("wr_release_dq_off", 32'(dut.dq_oe), 32'd0);
    chk("wr_release_busy", 32'(status), 32'd1);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (!we_n || status != 1'b1 || ce_n != 2'b11) hold_bad++;
    end
    if (hold > 0) chk("wr_stale_hold", 32'(hold_bad), 32'd0);
    cmd = 2'b00;
    @(negedge clk);
    chk("wr_back_idle", 32'(status), 32'd0);
  endtask

  task automatic do_read(input logic cs, input logic [17:0] a,
                         input logic [15:0] expd);
    int oe_low = 0;
    @(negedge clk);
    cmd = 2'b01; cs_in = cs; addr_in = a; data_in = 16'h0000;
    #1 chk("rd_status_same_cycle", 32'(status), 32'd1);
    exp_q.push_back('{data: expd, due: cyc + 4});
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) cmd = 2'b00;
      if (!oe_n && ce_n == (cs ? 2'b01 : 2'b10) && sram_addr == a) oe_low++;
    end
    chk("rd_oe_low_cycles", 32'(oe_low), 32'd3);
    chk("rd_release_ce", 32'(ce_n), 32'(2'b11));
    @(negedge clk);
    chk("rd_back_idle", 32'(status), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; cmd = 2'b00; addr_in = '0; cs_in = 1'b0; data_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_ce", 32'(ce_n), 32'(2'b11));
    chk("rst_oe_we", 32'({oe_n, we_n}), 32'(2'b11));
    chk("rst_addr", 32'(sram_addr), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_status", 32'(status), 32'd0);
    chk("rst_dq_off", 32'(dut.dq_oe), 32'd0);
    rst_n = 1'b1;

    do_write(1'b0, 18'h00012, 16'hA5C3, 0);
    chk("mem0_a5c3", 32'(mem0.exists(18'h00012) ? mem0[18'h00012] : 16'h0),
        32'h0000A5C3);
    do_read(1'b0, 18'h00012, 16'hA5C3);

    do_write(1'b1, 18'h3FFFF, 16'hFFFF, 0);
    chk("mem1_ffff", 32'(mem1.exists(18'h3FFFF) ? mem1[18'h3FFFF] : 16'h0),
        32'h0000FFFF);
    chk("mem0_untouched", 32'(mem0.exists(18'h3FFFF)), 32'd0);
    do_read(1'b1, 18'h3FFFF, 16'hFFFF);

    do_write(1'b0, 18'h00034, 16'h5A0F, 3);
    do_read(1'b0, 18'h00034, 16'h5A0F);

    @(negedge clk);
    cmd = 2'b11; addr_in = 18'h00055;
    #1 chk("cmd11_status", 32'(status), 32'd0);
    @(negedge clk);
    chk("cmd11_no_access", 32'({ce_n, oe_n, we_n}), 32'(4'b1111));
    cmd = 2'b00;

    // Reset in the middle of a write pulse
    @(negedge clk);
    cmd = 2'b10; cs_in = 1'b1; addr_in = 18'h00200; data_in = 16'h1234;
    repeat (2) @(negedge clk);
    chk("midrst_we_active", 32'(we_n), 32'd0);
    rst_n = 1'b0; cmd = 2'b00;
    @(negedge clk);
    chk("midrst_pins_idle", 32'({ce_n, we_n, dut.dq_oe}), 32'(4'b1110));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("postrst_status", 32'(status), 32'd0);
    chk("postrst_pins", 32'({ce_n, oe_n, we_n, dut.dq_oe}), 32'(5'b11110));

    do_read(1'b0, 18'h00012, 16'hA5C3);

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    chk("bus_invariants", 32'(viol), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
